// File: rtl/tlp_xcvr_pkg.sv
// rtl/tlp_xcvr_pkg.sv - shared C2F ring geometry, word types and consumer FSM states
package tlp_xcvr_pkg;

   // Byte size of the C2F ring is 2**C2F_SIZE_NBITS, split into fixed-size chunks.
   localparam int C2F_SIZE_NBITS = 12;
   localparam int C2F_CHUNKSIZE  = 128;
   localparam int C2F_QWORDS     = C2F_CHUNKSIZE / 8;
   localparam int C2F_PTR_NBITS  = C2F_SIZE_NBITS - $clog2(C2F_CHUNKSIZE);
   localparam int C2F_OFF_NBITS  = $clog2(C2F_QWORDS);

   typedef logic [C2F_PTR_NBITS-1:0] C2FChunkPtr;
   typedef logic [C2F_OFF_NBITS-1:0] C2FChunkOffset;
   typedef logic [63:0]              uint64;
   typedef logic [31:0]              uint32;

   typedef enum logic [1:0] {
      CS_IDLE,
      CS_READ,
      CS_DRAIN,
      CS_ACK
   } ConsumerState;

endpackage

// File: rtl/example_consumer_core.sv
// rtl/example_consumer_core.sv - drains C2F chunks from ring RAM and checksums a programmable number of qwords
module example_consumer_core
   import tlp_xcvr_pkg::*;
(
   input  logic          sysClk_in,
   input  logic          csReset_in,
   input  C2FChunkPtr    cpuWrPtr_in,
   input  C2FChunkPtr    cpuRdPtr_in,
   output logic          dtAck_out,
   output C2FChunkOffset rdOffset_out,
   input  uint64         rdData_in,
   output uint64         csData_out,
   output logic          csValid_out,
   input  uint32         countInit_in
);

   localparam C2FChunkOffset LAST_OFFSET = C2FChunkOffset'(C2F_QWORDS - 1);

   ConsumerState state;
   logic         issued;
   uint32        wordsLeft;

   always_ff @(posedge sysClk_in) begin
      if (csReset_in) begin
         state        <= CS_IDLE;
         dtAck_out    <= 1'b0;
         rdOffset_out <= '0;
         issued       <= 1'b0;
         csData_out   <= '0;
         wordsLeft    <= countInit_in;
         csValid_out  <= (countInit_in == 32'd0);
      end else begin
         // RAM read is registered, so data for an offset issued now arrives next cycle.
         issued    <= (state == CS_READ);
         dtAck_out <= 1'b0;

         case (state)
            CS_IDLE: begin
               rdOffset_out <= '0;
               if (cpuWrPtr_in != cpuRdPtr_in) begin
                  state <= CS_READ;
               end
            end
            CS_READ: begin
               if (rdOffset_out == LAST_OFFSET) begin
                  rdOffset_out <= '0;
                  state        <= CS_DRAIN;
               end else begin
                  rdOffset_out <= rdOffset_out + 1'b1;
               end
            end
            CS_DRAIN: begin
               dtAck_out <= 1'b1;
               state     <= CS_ACK;
            end
            CS_ACK: begin
               state <= CS_IDLE;
            end
            default: begin
               state <= CS_IDLE;
            end
         endcase

         // Once the count is exhausted the sum freezes but chunks keep draining.
         if (issued && (wordsLeft != 32'd0)) begin
            csData_out <= csData_out + rdData_in;
            wordsLeft  <= wordsLeft - 32'd1;
            if (wordsLeft == 32'd1) begin
               csValid_out <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_example_consumer_core.sv
// tb/tb_example_consumer_core.sv - randomized self-checking bench for example_consumer_core
module tb_example_consumer_core;
   import tlp_xcvr_pkg::*;

   logic          sysClk = 1'b0;
   logic          csReset;
   C2FChunkPtr    wrPtr;
   C2FChunkPtr    rdPtr;
   logic          dtAck;
   C2FChunkOffset rdOffset;
   uint64         rdData;
   uint64         csData;
   logic          csValid;
   uint32         countInit;

   logic          ptrLoad;
   C2FChunkPtr    ptrLoadVal;
   uint64         ram [0:(2**(C2F_PTR_NBITS+C2F_OFF_NBITS))-1];

   int vectors = 0;
   int miscompares = 0;
   int ackCount = 0;
   int offNz = 0;
   int offErr = 0;
   int ackDouble = 0;
   logic lastAck = 1'b0;
   C2FChunkOffset lastOff = '0;

   always #5 sysClk = ~sysClk;

   example_consumer_core dut (
      .sysClk_in    (sysClk),
      .csReset_in   (csReset),
      .cpuWrPtr_in  (wrPtr),
      .cpuRdPtr_in  (rdPtr),
      .dtAck_out    (dtAck),
      .rdOffset_out (rdOffset),
      .rdData_in    (rdData),
      .csData_out   (csData),
      .csValid_out  (csValid),
      .countInit_in (countInit)
   );

   // External read-pointer register and registered-read RAM.
   always @(posedge sysClk) begin
      if (ptrLoad) rdPtr <= ptrLoadVal;
      else if (dtAck) rdPtr <= rdPtr + 1'b1;
      rdData <= ram[{rdPtr, rdOffset}];
   end

   always @(posedge sysClk) begin
      if (dtAck) ackCount <= ackCount + 1;
      if (dtAck && lastAck) ackDouble <= ackDouble + 1;
      lastAck <= dtAck;
      if (rdOffset != '0) begin
         offNz <= offNz + 1;
         if (rdOffset != C2FChunkOffset'(lastOff + 1'b1)) offErr <= offErr + 1;
      end
      lastOff <= rdOffset;
   end

   task automatic doReset(input uint32 cnt, input C2FChunkPtr startPtr);
      @(negedge sysClk);
      csReset = 1'b1; countInit = cnt; ptrLoad = 1'b1; ptrLoadVal = startPtr; wrPtr = startPtr;
      @(negedge sysClk);
      csReset = 1'b0; ptrLoad = 1'b0;
   endtask

   task automatic waitAcks(input int base, input int n, input string name);
      int budget = n * (C2F_QWORDS + 3) + 20;
      while ((ackCount - base) < n && budget > 0) begin
         @(negedge sysClk);
         budget--;
      end
      repeat (4) @(negedge sysClk);
      vectors++;
      if (ackCount - base != n) begin
         miscompares++;
         $display("FAIL %s_acks: got %0d expected %0d", name, ackCount - base, n);
      end
   endtask

   task automatic checkSum(input string name, input uint64 expSum, input logic expValid, input C2FChunkPtr expPtr);
      vectors++;
      if (csData !== expSum) begin
         miscompares++;
         $display("FAIL %s_csData: got %0h expected %0h", name, csData, expSum);
      end
      vectors++;
      if (csValid !== expValid) begin
         miscompares++;
         $display("FAIL %s_csValid: got %0b expected %0b", name, csValid, expValid);
      end
      vectors++;
      if (rdPtr !== expPtr) begin
         miscompares++;
         $display("FAIL %s_rdPtr: got %0d expected %0d", name, rdPtr, expPtr);
      end
   endtask

   task automatic test_reset();
      doReset(32'd16, '0);
      vectors++;
      if ({dtAck, rdOffset, csData, csValid} !== {1'b0, C2FChunkOffset'(0), 64'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack=%0b off=%0d cs=%0h v=%0b expected 0/0/0/0",
                  dtAck, rdOffset, csData, csValid);
      end
      doReset(32'd0, '0);
      vectors++;
      if (csValid !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_zero_count_valid: got %0b expected 1", csValid);
      end
   endtask

   task automatic test_empty();
      int bad = 0;
      int base;
      doReset(32'd16, '0);
      base = ackCount;
      repeat (50) begin
         @(negedge sysClk);
         if (dtAck !== 1'b0 || rdOffset !== '0 || csValid !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0 || ackCount != base) begin
         miscompares++;
         $display("FAIL empty_idle: got %0d bad cycles %0d acks expected 0 0", bad, ackCount - base);
      end
   endtask

   task automatic test_one_chunk();
      int base, nzBase;
      doReset(32'd16, '0);
      for (int i = 0; i < C2F_QWORDS; i++) ram[{C2FChunkPtr'(0), C2FChunkOffset'(i)}] = 64'(i + 1);
      base = ackCount; nzBase = offNz;
      wrPtr = C2FChunkPtr'(1);
      waitAcks(base, 1, "one_chunk");
      vectors++;
      if (offNz - nzBase != C2F_QWORDS - 1) begin
         miscompares++;
         $display("FAIL one_chunk_offsets: got %0d expected %0d", offNz - nzBase, C2F_QWORDS - 1);
      end
      checkSum("one_chunk", 64'd136, 1'b1, C2FChunkPtr'(1));
   endtask

   task automatic test_back_to_back();
      int base;
      doReset(32'd128, '0);
      for (int c = 0; c < 8; c++)
         for (int i = 0; i < C2F_QWORDS; i++)
            ram[{C2FChunkPtr'(c), C2FChunkOffset'(i)}] = 64'(c * C2F_QWORDS + i + 1);
      base = ackCount;
      wrPtr = C2FChunkPtr'(8);
      waitAcks(base, 8, "eight_chunks");
      checkSum("eight_chunks", 64'd8256, 1'b1, C2FChunkPtr'(8));
   endtask

   task automatic test_partial_count();
      int base;
      int budget = 40;
      doReset(32'd8, '0);
      for (int i = 0; i < C2F_QWORDS; i++) ram[{C2FChunkPtr'(0), C2FChunkOffset'(i)}] = 64'(i + 1);
      base = ackCount;
      wrPtr = C2FChunkPtr'(1);
      while (csValid !== 1'b1 && budget > 0) begin
         @(negedge sysClk);
         budget--;
      end
      vectors++;
      if (csValid !== 1'b1 || ackCount != base) begin
         miscompares++;
         $display("FAIL partial_valid_midchunk: got valid=%0b acks=%0d expected 1 0", csValid, ackCount - base);
      end
      waitAcks(base, 1, "partial");
      checkSum("partial", 64'd36, 1'b1, C2FChunkPtr'(1));
   endtask

   task automatic test_overflow();
      int base;
      doReset(32'd2, '0);
      ram[{C2FChunkPtr'(0), C2FChunkOffset'(0)}] = 64'hFFFF_FFFF_FFFF_FFFF;
      ram[{C2FChunkPtr'(0), C2FChunkOffset'(1)}] = 64'd2;
      for (int i = 2; i < C2F_QWORDS; i++) ram[{C2FChunkPtr'(0), C2FChunkOffset'(i)}] = {$urandom, $urandom};
      base = ackCount;
      wrPtr = C2FChunkPtr'(1);
      waitAcks(base, 1, "overflow");
      checkSum("overflow", 64'd1, 1'b1, C2FChunkPtr'(1));
   endtask

   task automatic test_reset_mid_chunk();
      int base;
      int budget = 40;
      uint64 expSum = 0;
      doReset(32'd16, '0);
      for (int i = 0; i < C2F_QWORDS; i++) begin
         ram[{C2FChunkPtr'(0), C2FChunkOffset'(i)}] = {$urandom, $urandom};
         expSum += ram[{C2FChunkPtr'(0), C2FChunkOffset'(i)}];
      end
      base = ackCount;
      wrPtr = C2FChunkPtr'(1);
      while (rdOffset != C2FChunkOffset'(5) && budget > 0) begin
         @(negedge sysClk);
         budget--;
      end
      csReset = 1'b1; countInit = 32'd16;
      @(negedge sysClk);
      csReset = 1'b0;
      vectors++;
      if (ackCount != base || rdPtr !== C2FChunkPtr'(0) || csData !== 64'd0 || rdOffset !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_abandon: got acks=%0d ptr=%0d cs=%0h off=%0d expected 0 0 0 0",
                  ackCount - base, rdPtr, csData, rdOffset);
      end
      waitAcks(base, 1, "reset_mid_reread");
      checkSum("reset_mid_reread", expSum, 1'b1, C2FChunkPtr'(1));
   endtask

   task automatic test_random();
      for (int iter = 0; iter < 6; iter++) begin
         uint64 words[$];
         uint64 expSum = 0;
         C2FChunkPtr start = C2FChunkPtr'($urandom_range(0, 2**C2F_PTR_NBITS - 1));
         int n = $urandom_range(1, 5);
         int total = n * C2F_QWORDS;
         int cnt = (iter == 0) ? 0 : $urandom_range(0, total + 4);
         int base, nzBase;
         doReset(uint32'(cnt), start);
         for (int c = 0; c < n; c++)
            for (int i = 0; i < C2F_QWORDS; i++) begin
               uint64 w = {$urandom, $urandom};
               ram[{C2FChunkPtr'(start + c), C2FChunkOffset'(i)}] = w;
               words.push_back(w);
            end
         for (int k = 0; k < cnt && k < total; k++) expSum += words[k];
         base = ackCount; nzBase = offNz;
         wrPtr = C2FChunkPtr'(start + n);
         waitAcks(base, n, "random");
         vectors++;
         if (offNz - nzBase != n * (C2F_QWORDS - 1)) begin
            miscompares++;
            $display("FAIL random_offsets: got %0d expected %0d", offNz - nzBase, n * (C2F_QWORDS - 1));
         end
         checkSum("random", expSum, (cnt <= total) ? 1'b1 : 1'b0, C2FChunkPtr'(start + n));
      end
   endtask

   initial begin
      csReset = 1'b1; countInit = '0; wrPtr = '0; ptrLoad = 1'b1; ptrLoadVal = '0;
      for (int i = 0; i < 2**(C2F_PTR_NBITS+C2F_OFF_NBITS); i++) ram[i] = '0;
      test_reset();
      test_empty();
      test_one_chunk();
      test_back_to_back();
      test_partial_count();
      test_overflow();
      test_reset_mid_chunk();
      test_random();
      vectors++;
      if (offErr != 0 || ackDouble != 0) begin
         miscompares++;
         $display("FAIL sequence_integrity: got offErr=%0d ackDouble=%0d expected 0 0", offErr, ackDouble);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
